// File: rtl/apb2axi_rd_drain_engine.sv
// Per-tag read-data drain: buffers AXI R beats in per-tag FIFOs and hands them out as APB-width words.
// Optional error reporting via macro APB2AXI_RD_DRAIN_ERR_EN (err_vld/err_tag/err_resp).
module apb2axi_rd_drain_engine #(
  parameter int TAG_W     = 4,
  parameter int N_TAG     = 1 << TAG_W,
  parameter int DATA_W    = 64,
  parameter int APB_W     = 32,
  parameter int TAG_DEPTH = 8
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              rdf_pop_valid,
  input  logic [TAG_W-1:0]  rdf_pop_tag,
  input  logic [DATA_W-1:0] rdf_pop_data,
  input  logic [1:0]        rdf_pop_resp,
  input  logic              rdf_pop_last,
  output logic              rdf_pop_ready,
  input  logic              data_req,
  input  logic [TAG_W-1:0]  data_req_tag,
  output logic              data_valid,
  input  logic              data_ready,
  output logic [APB_W-1:0]  data_out,
  output logic [1:0]        data_resp,
  output logic              data_last,
  input  logic              flush_vld,
  input  logic [TAG_W-1:0]  flush_tag,
  output logic [N_TAG-1:0]  tag_nonempty
`ifdef APB2AXI_RD_DRAIN_ERR_EN
  ,
  output logic              err_vld,
  output logic [TAG_W-1:0]  err_tag,
  output logic [1:0]        err_resp
`endif
);

  localparam int R     = DATA_W / APB_W;
  localparam int WI_W  = (R > 1) ? $clog2(R) : 1;
  localparam int PTR_W = $clog2(TAG_DEPTH);
  localparam int CNT_W = $clog2(TAG_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(TAG_DEPTH);
  localparam logic [WI_W-1:0]  LAST_WI  = WI_W'(R - 1);

  if ((DATA_W % APB_W) != 0 || R < 1 || (R & (R - 1)) != 0) begin : g_bad_ratio
    $error("DATA_W must be a power-of-2 multiple of APB_W");
  end
  if (TAG_DEPTH < 2 || (TAG_DEPTH & (TAG_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("TAG_DEPTH must be a power of 2 and at least 2");
  end
  if (N_TAG > (1 << TAG_W)) begin : g_bad_ntag
    $error("N_TAG exceeds the tag index range");
  end

  logic [DATA_W-1:0] mem_data [N_TAG][TAG_DEPTH];
  logic [1:0]        mem_resp [N_TAG][TAG_DEPTH];
  logic              mem_last [N_TAG][TAG_DEPTH];

  logic [PTR_W-1:0]  head     [N_TAG];
  logic [PTR_W-1:0]  tail     [N_TAG];
  logic [CNT_W-1:0]  count    [N_TAG];
  logic [WI_W-1:0]   word_idx [N_TAG];

  logic              push_p0, issue_p0, pop_p0;
  logic [PTR_W-1:0]  rq_head;
  logic [WI_W-1:0]   rq_wi;
  logic [DATA_W-1:0] head_shift;
  logic [APB_W-1:0]  word_sel;
  logic [N_TAG-1:0]  push_vec, issue_vec, pop_vec, flush_vec;

  // Stage p0: accept/issue decisions from current FIFO state
  always_comb begin
    rdf_pop_ready = preset ||
                    ((count[rdf_pop_tag] < FULL_CNT) && !(flush_vld && flush_tag == rdf_pop_tag));
    push_p0    = rdf_pop_valid && rdf_pop_ready && !preset;
    issue_p0   = data_req && (count[data_req_tag] != '0) && (!data_valid || data_ready) &&
                 !(flush_vld && flush_tag == data_req_tag);
    rq_head    = head[data_req_tag];
    rq_wi      = word_idx[data_req_tag];
    pop_p0     = issue_p0 && (rq_wi == LAST_WI);
    head_shift = mem_data[data_req_tag][rq_head] >> (APB_W * int'(rq_wi));
    word_sel   = head_shift[APB_W-1:0];
  end

  always_comb begin
    push_vec     = '0;
    issue_vec    = '0;
    pop_vec      = '0;
    flush_vec    = '0;
    tag_nonempty = '0;
    for (int t = 0; t < N_TAG; t++) begin
      push_vec[t]     = push_p0  && (rdf_pop_tag  == TAG_W'(t));
      issue_vec[t]    = issue_p0 && (data_req_tag == TAG_W'(t));
      pop_vec[t]      = pop_p0   && (data_req_tag == TAG_W'(t));
      flush_vec[t]    = flush_vld && (flush_tag   == TAG_W'(t));
      tag_nonempty[t] = !preset && (count[t] != '0);
    end
  end

  // Storage is never reset; pointers alone decide what is valid.
  always_ff @(posedge pclk) begin
    if (push_p0) begin
      mem_data[rdf_pop_tag][tail[rdf_pop_tag]] <= rdf_pop_data;
      mem_resp[rdf_pop_tag][tail[rdf_pop_tag]] <= rdf_pop_resp;
      mem_last[rdf_pop_tag][tail[rdf_pop_tag]] <= rdf_pop_last;
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      for (int t = 0; t < N_TAG; t++) begin
        head[t]     <= '0;
        tail[t]     <= '0;
        count[t]    <= '0;
        word_idx[t] <= '0;
      end
    end else begin
      for (int t = 0; t < N_TAG; t++) begin
        if (flush_vec[t]) begin
          head[t]     <= '0;
          tail[t]     <= '0;
          count[t]    <= '0;
          word_idx[t] <= '0;
        end else begin
          if (push_vec[t])  tail[t] <= tail[t] + 1'b1;
          if (pop_vec[t])   head[t] <= head[t] + 1'b1;
          if (issue_vec[t]) word_idx[t] <= (word_idx[t] == LAST_WI) ? '0 : word_idx[t] + 1'b1;
          if (push_vec[t] && !pop_vec[t])      count[t] <= count[t] + 1'b1;
          else if (pop_vec[t] && !push_vec[t]) count[t] <= count[t] - 1'b1;
        end
      end
    end
  end

  // Stage p1: registered word presentation
  always_ff @(posedge pclk) begin
    if (preset) begin
      data_valid <= 1'b0;
      data_out   <= '0;
      data_resp  <= '0;
      data_last  <= 1'b0;
    end else if (issue_p0) begin
      data_valid <= 1'b1;
      data_out   <= word_sel;
      data_resp  <= mem_resp[data_req_tag][rq_head];
      data_last  <= mem_last[data_req_tag][rq_head] && (rq_wi == LAST_WI);
    end else if (data_valid && data_ready) begin
      data_valid <= 1'b0;
      data_last  <= 1'b0;
    end
  end

`ifdef APB2AXI_RD_DRAIN_ERR_EN
  always_ff @(posedge pclk) begin
    if (preset) begin
      err_vld  <= 1'b0;
      err_tag  <= '0;
      err_resp <= '0;
    end else begin
      err_vld <= push_p0 && (rdf_pop_resp != 2'b00);
      if (push_p0 && (rdf_pop_resp != 2'b00)) begin
        err_tag  <= rdf_pop_tag;
        err_resp <= rdf_pop_resp;
      end
    end
  end
`endif

endmodule

// File: tb/tb_apb2axi_rd_drain_engine.sv
// Directed plus randomized bench for apb2axi_rd_drain_engine against a word-queue reference model.
module tb_apb2axi_rd_drain_engine;
  localparam int TAG_W = 4, N_TAG = 16, DATA_W = 64, APB_W = 32, TAG_DEPTH = 8;
  localparam int R = DATA_W / APB_W;

  typedef struct packed {
    logic [APB_W-1:0] w;
    logic [1:0]       resp;
    logic             last;
  } word_t;

  logic              pclk = 1'b0;
  logic              preset = 1'b1;
  logic              rdf_pop_valid = 1'b0;
  logic [TAG_W-1:0]  rdf_pop_tag = '0;
  logic [DATA_W-1:0] rdf_pop_data = '0;
  logic [1:0]        rdf_pop_resp = '0;
  logic              rdf_pop_last = 1'b0;
  logic              rdf_pop_ready;
  logic              data_req = 1'b0;
  logic [TAG_W-1:0]  data_req_tag = '0;
  logic              data_valid;
  logic              data_ready = 1'b1;
  logic [APB_W-1:0]  data_out;
  logic [1:0]        data_resp;
  logic              data_last;
  logic              flush_vld = 1'b0;
  logic [TAG_W-1:0]  flush_tag = '0;
  logic [N_TAG-1:0]  tag_nonempty;
`ifdef APB2AXI_RD_DRAIN_ERR_EN
  logic              err_vld;
  logic [TAG_W-1:0]  err_tag;
  logic [1:0]        err_resp;
  logic              ex_err_vld = 1'b0;
  logic [TAG_W-1:0]  ex_err_tag = '0;
  logic [1:0]        ex_err_resp = '0;
`endif

  apb2axi_rd_drain_engine #(.TAG_W(TAG_W), .N_TAG(N_TAG), .DATA_W(DATA_W), .APB_W(APB_W),
                            .TAG_DEPTH(TAG_DEPTH)) dut (
    .pclk(pclk), .preset(preset),
    .rdf_pop_valid(rdf_pop_valid), .rdf_pop_tag(rdf_pop_tag), .rdf_pop_data(rdf_pop_data),
    .rdf_pop_resp(rdf_pop_resp), .rdf_pop_last(rdf_pop_last), .rdf_pop_ready(rdf_pop_ready),
    .data_req(data_req), .data_req_tag(data_req_tag), .data_valid(data_valid),
    .data_ready(data_ready), .data_out(data_out), .data_resp(data_resp), .data_last(data_last),
    .flush_vld(flush_vld), .flush_tag(flush_tag), .tag_nonempty(tag_nonempty)
`ifdef APB2AXI_RD_DRAIN_ERR_EN
    , .err_vld(err_vld), .err_tag(err_tag), .err_resp(err_resp)
`endif
  );

  always #5 pclk = ~pclk;

  int checks = 0;
  int failures = 0;

  // Reference model: each tag is a queue of APB words still to be delivered.
  word_t            mq [N_TAG][$];
  logic             exp_valid = 1'b0;
  logic [APB_W-1:0] exp_data = '0;
  logic [1:0]       exp_resp = '0;
  logic             exp_last = 1'b0;

  function automatic int beats(input int t);
    return (mq[t].size() + R - 1) / R;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int t = 0; t < N_TAG; t++) mq[t].delete();
    exp_valid = 1'b0; exp_data = '0; exp_resp = '0; exp_last = 1'b0;
  endtask

  // One clock: check combinational outputs, advance the model, then check registered outputs.
  task automatic cycle();
    logic [N_TAG-1:0] ne;
    logic ex_ready, do_push, do_issue;
    word_t w;
    #1;
    for (int t = 0; t < N_TAG; t++) ne[t] = (beats(t) > 0);
    chk("tag_nonempty", 64'(tag_nonempty), 64'(ne));
    ex_ready = (beats(int'(rdf_pop_tag)) < TAG_DEPTH) && !(flush_vld && flush_tag == rdf_pop_tag);
    chk("rdf_pop_ready", 64'(rdf_pop_ready), 64'(ex_ready));
    do_push  = rdf_pop_valid && ex_ready;
    do_issue = data_req && (beats(int'(data_req_tag)) > 0) && (!exp_valid || data_ready) &&
               !(flush_vld && flush_tag == data_req_tag);
    if (do_issue) begin
      w = mq[data_req_tag].pop_front();
      exp_valid = 1'b1; exp_data = w.w; exp_resp = w.resp; exp_last = w.last;
    end else if (exp_valid && data_ready) begin
      exp_valid = 1'b0; exp_last = 1'b0;
    end
    if (flush_vld) mq[flush_tag].delete();
    if (do_push)
      for (int k = 0; k < R; k++)
        mq[rdf_pop_tag].push_back({rdf_pop_data[k*APB_W +: APB_W], rdf_pop_resp,
                                   rdf_pop_last && (k == R - 1)});
`ifdef APB2AXI_RD_DRAIN_ERR_EN
    ex_err_vld = do_push && (rdf_pop_resp != 2'b00);
    if (ex_err_vld) begin ex_err_tag = rdf_pop_tag; ex_err_resp = rdf_pop_resp; end
`endif
    @(posedge pclk);
    #1;
    chk("data_valid", 64'(data_valid), 64'(exp_valid));
    chk("data_last", 64'(data_last), 64'(exp_last));
    if (exp_valid) begin
      chk("data_out", 64'(data_out), 64'(exp_data));
      chk("data_resp", 64'(data_resp), 64'(exp_resp));
    end
`ifdef APB2AXI_RD_DRAIN_ERR_EN
    chk("err_vld", 64'(err_vld), 64'(ex_err_vld));
    if (ex_err_vld) begin
      chk("err_tag", 64'(err_tag), 64'(ex_err_tag));
      chk("err_resp", 64'(err_resp), 64'(ex_err_resp));
    end
`endif
  endtask

  task automatic push(input int tag, input logic [DATA_W-1:0] d, input logic [1:0] rs,
                      input logic lst);
    rdf_pop_valid = 1'b1; rdf_pop_tag = TAG_W'(tag); rdf_pop_data = d;
    rdf_pop_resp = rs; rdf_pop_last = lst;
    cycle();
    rdf_pop_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    data_req = 1'b0; data_ready = 1'b1; flush_vld = 1'b0; rdf_pop_valid = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic drain(input int tag, input int n);
    data_req = 1'b1; data_req_tag = TAG_W'(tag); data_ready = 1'b1;
    for (int i = 0; i < n; i++) cycle();
    data_req = 1'b0;
  endtask

  logic [APB_W-1:0] held;

  initial begin
    // Reset state
    @(posedge pclk);
    #1;
    chk("rst_ready", 64'(rdf_pop_ready), 64'd1);
    chk("rst_nonempty", 64'(tag_nonempty), 64'd0);
    chk("rst_valid", 64'(data_valid), 64'd0);
    chk("rst_data_out", 64'(data_out), 64'd0);
    chk("rst_data_resp", 64'(data_resp), 64'd0);
    chk("rst_data_last", 64'(data_last), 64'd0);
    model_reset();
    preset = 1'b0;
    idle(1);

    // Two beats on tag 3, drained as four words
    push(3, 64'h11112222_33334444, 2'b00, 1'b0);
    push(3, 64'h55556666_77778888, 2'b00, 1'b1);
    data_req = 1'b1; data_req_tag = 4'd3; data_ready = 1'b1;
    cycle(); chk("t3_w0", 64'(data_out), 64'h33334444); chk("t3_l0", 64'(data_last), 64'd0);
    cycle(); chk("t3_w1", 64'(data_out), 64'h11112222); chk("t3_l1", 64'(data_last), 64'd0);
    cycle(); chk("t3_w2", 64'(data_out), 64'h77778888); chk("t3_l2", 64'(data_last), 64'd0);
    cycle(); chk("t3_w3", 64'(data_out), 64'h55556666); chk("t3_l3", 64'(data_last), 64'd1);
    data_req = 1'b0;
    cycle(); chk("t3_empty", 64'(tag_nonempty[3]), 64'd0);

    // Fill tag 5, check backpressure, then wrap around
    for (int i = 0; i < TAG_DEPTH; i++) push(5, {$urandom, $urandom}, 2'b00, i == TAG_DEPTH - 1);
    rdf_pop_tag = 4'd5; #1; chk("t5_full_ready", 64'(rdf_pop_ready), 64'd0);
    rdf_pop_tag = 4'd6; #1; chk("t6_ready", 64'(rdf_pop_ready), 64'd1);
    drain(5, R);
    rdf_pop_tag = 4'd5; #1; chk("t5_ready_back", 64'(rdf_pop_ready), 64'd1);
    for (int i = 0; i < 2 * TAG_DEPTH; i++) begin
      rdf_pop_valid = 1'b1; rdf_pop_tag = 4'd5; rdf_pop_data = {$urandom, $urandom};
      rdf_pop_resp = 2'b00; rdf_pop_last = 1'($urandom_range(0, 1));
      data_req = (i % 2 == 1); data_req_tag = 4'd5; data_ready = 1'b1;
      cycle();
    end
    rdf_pop_valid = 1'b0;
    drain(5, TAG_DEPTH * R + 2);

    // Consumer stall with requests held high
    push(1, 64'hAAAA0001_BBBB0002, 2'b01, 1'b0);
    push(1, 64'hCCCC0003_DDDD0004, 2'b01, 1'b1);
    data_req = 1'b1; data_req_tag = 4'd1; data_ready = 1'b0;
    cycle();
    held = data_out;
    chk("stall_first", 64'(held), 64'hBBBB0002);
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("stall_hold", 64'(data_out), 64'(held));
    end
    data_ready = 1'b1;
    cycle(); chk("stall_next", 64'(data_out), 64'hAAAA0001);
    drain(1, 3);
    idle(1);

    // Flush tag 2 against a same-cycle request; tag 4 untouched
    for (int i = 0; i < 3; i++) push(2, {$urandom, $urandom}, 2'b00, i == 2);
    push(4, 64'h44440000_44440001, 2'b00, 1'b0);
    push(4, 64'h44440002_44440003, 2'b00, 1'b1);
    flush_vld = 1'b1; flush_tag = 4'd2; data_req = 1'b1; data_req_tag = 4'd2; data_ready = 1'b1;
    cycle(); chk("flush_ignored", 64'(data_valid), 64'd0);
    flush_vld = 1'b0; data_req = 1'b0;
    cycle(); chk("flush_t2_empty", 64'(tag_nonempty[2]), 64'd0);
    chk("flush_t4_kept", 64'(tag_nonempty[4]), 64'd1);
    drain(4, 2 * R + 1);

`ifdef APB2AXI_RD_DRAIN_ERR_EN
    // Error pulse on a SLVERR beat
    push(7, 64'h70000001_70000002, 2'b10, 1'b1);
    chk("err_pulse", 64'(err_vld), 64'd1);
    chk("err_tag7", 64'(err_tag), 64'd7);
    chk("err_resp10", 64'(err_resp), 64'd2);
    cycle(); chk("err_single", 64'(err_vld), 64'd0);
    data_req = 1'b1; data_req_tag = 4'd7;
    cycle(); chk("err_w0_resp", 64'(data_resp), 64'd2);
    cycle(); chk("err_w1_resp", 64'(data_resp), 64'd2);
    data_req = 1'b0;
    idle(1);
`endif

    // Randomized traffic on a few tags
    for (int i = 0; i < 600; i++) begin
      rdf_pop_valid = 1'($urandom_range(0, 1));
      rdf_pop_tag   = TAG_W'($urandom_range(0, 3));
      rdf_pop_data  = {$urandom, $urandom};
      rdf_pop_resp  = 2'($urandom_range(0, 3));
      rdf_pop_last  = 1'($urandom_range(0, 1));
      data_req      = ($urandom_range(0, 9) < 7);
      data_req_tag  = TAG_W'($urandom_range(0, 3));
      data_ready    = 1'($urandom_range(0, 1));
      flush_vld     = ($urandom_range(0, 24) == 0);
      flush_tag     = TAG_W'($urandom_range(0, 3));
      cycle();
    end
    idle(2);

    // Reset in the middle of a burst discards everything
    push(9, {$urandom, $urandom}, 2'b00, 1'b0);
    push(9, {$urandom, $urandom}, 2'b00, 1'b1);
    data_req = 1'b1; data_req_tag = 4'd9;
    cycle();
    data_req = 1'b0;
    preset = 1'b1;
    #1;
    chk("rst_mid_ready", 64'(rdf_pop_ready), 64'd1);
    chk("rst_mid_nonempty_comb", 64'(tag_nonempty), 64'd0);
    @(posedge pclk);
    #1;
    chk("rst_mid_valid", 64'(data_valid), 64'd0);
    chk("rst_mid_out", 64'(data_out), 64'd0);
    model_reset();
    preset = 1'b0;
    #1;
    chk("rst_mid_nonempty", 64'(tag_nonempty), 64'd0);
    idle(2);
    push(9, 64'h99990000_99990001, 2'b00, 1'b1);
    drain(9, R + 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
